// File: rtl/input_hub_pkg.sv
// Shared definitions for the memory-mapped input hub.
//   - MMIO_ADDR_BITS : word-address bits decoded inside the 16-word window
//   - REG_*          : register offsets inside the window
//   - STATUS_*       : bit positions inside the STATUS register
package input_hub_pkg;

  localparam int MMIO_ADDR_BITS = 4;

  localparam logic [MMIO_ADDR_BITS-1:0] REG_BTN_STATE = 4'd0;
  localparam logic [MMIO_ADDR_BITS-1:0] REG_BTN_PRESS = 4'd1;
  localparam logic [MMIO_ADDR_BITS-1:0] REG_ACCEL_X   = 4'd2;
  localparam logic [MMIO_ADDR_BITS-1:0] REG_ACCEL_Y   = 4'd3;
  localparam logic [MMIO_ADDR_BITS-1:0] REG_STATUS    = 4'd4;
  localparam logic [MMIO_ADDR_BITS-1:0] REG_FRAME_CNT = 4'd5;

  localparam int STATUS_VALID_BIT = 0;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchroniser followed by a debounce
// counter. The accepted level only changes after the synchronised input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   btn_raw      : asynchronous button input
//   stable       : debounced button level
//   rise         : one-cycle pulse in the first cycle stable reads 1
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  // The candidate level has been different for long enough to be accepted.
  assign commit = (sync_1 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_0 <= btn_raw;
      sync_1 <= sync_0;
      // rise is aligned with the first cycle in which stable is 1.
      rise   <= commit & sync_1;
      if (sync_1 == stable) begin
        cnt <= '0;
      end else if (commit) begin
        stable <= sync_1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_input_hub.sv
// Memory-mapped input hub sitting between the CPU data port and RAM.
// Conditions NUM_BTN push buttons (debounce + sticky press flags) and two
// accelerometer axes (decimated sampling + power-of-two moving average) and
// exposes them as registers in a 16-word window at MMIO_BASE.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   btn_raw            : asynchronous button inputs
//   accel_x_raw/_y_raw : unsigned accelerometer axes
//   addr, wren, data_in: CPU data-port word address, write enable, write data
//   ram_q              : RAM read data (1-cycle latency)
//   ram_wren           : write enable forwarded to RAM
//   q_out              : read data returned to the CPU
//
// Bus protocol: there is no valid/ready handshake. Every cycle is an access:
// a write takes effect at the next clock edge when wren is high; read data
// for the address presented in cycle N appears on q_out in cycle N+1, either
// from the hub registers (window hit) or from ram_q (miss). The hub never
// stalls, so the CPU may issue a new access every cycle.
module mmio_input_hub
  import input_hub_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ACCEL_W         = 9,
  parameter int unsigned SAMPLE_DIV      = 50000,
  parameter int unsigned AVG_LOG2        = 3,
  parameter logic [11:0] MMIO_BASE       = 12'hFF0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [ACCEL_W-1:0] accel_x_raw,
  input  logic [ACCEL_W-1:0] accel_y_raw,
  input  logic [11:0]        addr,
  input  logic               wren,
  input  logic [31:0]        data_in,
  input  logic [31:0]        ram_q,
  output logic               ram_wren,
  output logic [31:0]        q_out
);

  localparam int ACC_W  = ACCEL_W + AVG_LOG2;
  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SAMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << AVG_LOG2) - 1);

  // ---------------- address decode ----------------
  logic                      hit;
  logic                      wr_hit;
  logic [MMIO_ADDR_BITS-1:0] offset;

  assign offset   = addr[MMIO_ADDR_BITS-1:0];
  assign hit      = (addr[11:MMIO_ADDR_BITS] == MMIO_BASE[11:MMIO_ADDR_BITS]);
  assign wr_hit   = wren & hit;
  assign ram_wren = wren & ~hit;

  // ---------------- buttons ----------------
  logic [NUM_BTN-1:0] btn_state;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] press_clr;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .stable (btn_state[i]),
      .rise   (btn_rise[i])
    );
  end

  assign press_clr = (wr_hit && (offset == REG_BTN_PRESS)) ? data_in[NUM_BTN-1:0] : '0;

  // ---------------- accelerometer averaging ----------------
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [SAMP_W-1:0]  samp_cnt;
  logic               frame_done;
  logic [ACC_W-1:0]   acc_x;
  logic [ACC_W-1:0]   acc_y;
  logic [ACC_W-1:0]   sum_x;
  logic [ACC_W-1:0]   sum_y;
  logic [ACCEL_W-1:0] accel_x;
  logic [ACCEL_W-1:0] accel_y;
  logic [15:0]        frame_cnt;
  logic               valid;
  logic               valid_clr;

  assign tick       = (tick_cnt == TICK_LAST);
  assign frame_done = tick && (samp_cnt == SAMP_LAST);
  // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
  assign sum_x      = acc_x + ACC_W'(accel_x_raw);
  assign sum_y      = acc_y + ACC_W'(accel_y_raw);
  assign valid_clr  = wr_hit && (offset == REG_STATUS) && data_in[STATUS_VALID_BIT];

  // ---------------- read path ----------------
  logic [31:0] rdata_next;
  logic [31:0] rdata_q;
  logic        sel_q;
  logic        unused_data;

  // Only a few write-data bits are meaningful; the rest are ignored.
  assign unused_data = &{1'b0, data_in};

  always_comb begin
    rdata_next = '0;
    case (offset)
      REG_BTN_STATE: rdata_next[NUM_BTN-1:0]    = btn_state;
      REG_BTN_PRESS: rdata_next[NUM_BTN-1:0]    = press;
      REG_ACCEL_X:   rdata_next[ACCEL_W-1:0]    = accel_x;
      REG_ACCEL_Y:   rdata_next[ACCEL_W-1:0]    = accel_y;
      REG_STATUS:    rdata_next[STATUS_VALID_BIT] = valid;
      REG_FRAME_CNT: rdata_next[15:0]           = frame_cnt;
      default:       rdata_next                 = '0;
    endcase
  end

  assign q_out = sel_q ? rdata_q : ram_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt  <= '0;
      samp_cnt  <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      accel_x   <= '0;
      accel_y   <= '0;
      frame_cnt <= '0;
      valid     <= 1'b0;
      press     <= '0;
      sel_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (tick) begin
        if (frame_done) begin
          // Include the current sample in the average, then restart.
          accel_x   <= sum_x[ACC_W-1:AVG_LOG2];
          accel_y   <= sum_y[ACC_W-1:AVG_LOG2];
          acc_x     <= '0;
          acc_y     <= '0;
          samp_cnt  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          acc_x    <= sum_x;
          acc_y    <= sum_y;
          samp_cnt <= samp_cnt + 1'b1;
        end
      end

      // A set in the same cycle as a write-1-to-clear leaves the flag set.
      valid <= frame_done | (valid & ~valid_clr);
      press <= btn_rise | (press & ~press_clr);

      // Registered read captures the pre-update register contents.
      sel_q   <= hit;
      rdata_q <= rdata_next;
    end
  end

endmodule

// File: tb/tb_mmio_input_hub.sv
module tb_mmio_input_hub;

  localparam int NUM_BTN = 4;
  localparam int ACCEL_W = 9;

  logic               clock;
  logic               reset;
  logic [NUM_BTN-1:0] btn_raw;
  logic [ACCEL_W-1:0] accel_x_raw;
  logic [ACCEL_W-1:0] accel_y_raw;
  logic [11:0]        addr;
  logic               wren;
  logic [31:0]        data_in;
  logic [31:0]        ram_q;
  logic               ram_wren;
  logic [31:0]        q_out;

  mmio_input_hub #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(4),
    .ACCEL_W        (ACCEL_W),
    .SAMPLE_DIV     (2),
    .AVG_LOG2       (2),
    .MMIO_BASE      (12'hFF0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .accel_x_raw(accel_x_raw),
    .accel_y_raw(accel_y_raw),
    .addr       (addr),
    .wren       (wren),
    .data_in    (data_in),
    .ram_q      (ram_q),
    .ram_wren   (ram_wren),
    .q_out      (q_out)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- simple RAM model (1-cycle read latency) ----------------
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  end
  always @(posedge clock) begin
    if (ram_wren) mem[addr] <= data_in;
    ram_q <= mem[addr];
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        flag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bus cycle: drive the access, optionally check the combinational
  // ram_wren (exp_wren >= 0), advance one clock, then compare a queued read.
  task automatic tick_bus(input logic [11:0] a, input logic we, input logic [31:0] d,
                          input logic chk, input logic [31:0] exp, input string tag,
                          input int exp_wren);
    addr    = a;
    wren    = we;
    data_in = d;
    flag_q.push_back(chk);
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    if (exp_wren >= 0) begin
      #1;
      check("ram_wren", {31'b0, ram_wren}, exp_wren[31:0]);
    end
    @(posedge clock);
    #1;
    if (flag_q.pop_front()) begin
      check(tag_q.pop_front(), q_out, exp_q.pop_front());
    end
  endtask

  task automatic bus_idle();
    tick_bus(12'h000, 1'b0, 32'h0, 1'b0, 32'h0, "", -1);
  endtask

  task automatic bus_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
    tick_bus(a, 1'b0, 32'h0, 1'b1, exp, tag, -1);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input int exp_wren);
    tick_bus(a, 1'b1, d, 1'b0, 32'h0, "", exp_wren);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    btn_raw     = '0;
    accel_x_raw = '0;
    accel_y_raw = '0;
    addr        = '0;
    wren        = 1'b0;
    data_in     = '0;

    // Reset state
    tick_bus(12'h010, 1'b0, 32'h0, 1'b0, 32'h0, "", 0);
    bus_idle();
    bus_idle();
    check("q_out_in_reset", q_out, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) bus_read(12'hFF0 | 12'(i), 32'h0, "reset_reg");

    // Bouncing button 2, then held high: accepted 2+4 edges after hold start
    btn_raw[2] = 1'b1;
    bus_read(12'hFF0, 32'h0, "btn_bounce");
    btn_raw[2] = 1'b0;
    bus_read(12'hFF0, 32'h0, "btn_bounce");
    btn_raw[2] = 1'b1;
    for (int k = 0; k < 10; k++) bus_read(12'hFF0, (k >= 6) ? 32'h4 : 32'h0, "btn_state_timing");
    bus_read(12'hFF1, 32'h4, "btn_press_set");
    bus_write(12'hFF1, 32'h4, 0);
    bus_read(12'hFF1, 32'h0, "btn_press_w1c");

    // Release: stable returns to 0, falling edge must not set a press flag
    btn_raw[2] = 1'b0;
    repeat (9) bus_idle();
    bus_read(12'hFF0, 32'h0, "btn_release");
    bus_read(12'hFF1, 32'h0, "press_no_fall");

    // Press again; W1C lands on the exact edge the flag is set
    btn_raw[2] = 1'b1;
    repeat (6) bus_idle();
    bus_write(12'hFF1, 32'h4, 0);
    bus_read(12'hFF1, 32'h4, "press_set_wins");
    bus_read(12'hFF0, 32'h4, "btn_state_again");

    // Accelerometer average over four ticks
    btn_raw = '0;
    reset   = 1'b1;
    bus_idle();
    bus_idle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      accel_x_raw = ACCEL_W'(100 + 4 * i);
      accel_y_raw = ACCEL_W'(200 + 10 * i);
      bus_idle();
      bus_idle();
    end
    bus_read(12'hFF2, 32'd106, "accel_x_avg");
    bus_read(12'hFF3, 32'd215, "accel_y_avg");
    bus_read(12'hFF4, 32'h1, "status_valid");
    bus_read(12'hFF5, 32'h1, "frame_cnt_one");
    bus_write(12'hFF4, 32'h1, 0);
    bus_read(12'hFF4, 32'h0, "status_w1c");
    bus_write(12'hFF2, 32'h1FF, 0);
    bus_read(12'hFF2, 32'd106, "accel_x_ro");

    // Pass-through and read-only / reserved offsets
    repeat (10) bus_idle();
    bus_write(12'h010, 32'hDEAD, 1);
    bus_write(12'hFF3, 32'h1FF, 0);
    bus_read(12'hFF3, 32'd230, "accel_y_ro");
    bus_read(12'h010, 32'hDEAD, "ram_passthru");
    bus_write(12'hFF7, 32'hFFFF, 0);
    bus_read(12'hFF7, 32'h0, "reserved_zero");

    // Reset after three of four accumulation ticks discards the partial sum
    reset = 1'b1;
    bus_idle();
    bus_idle();
    reset       = 1'b0;
    accel_x_raw = ACCEL_W'(500);
    accel_y_raw = ACCEL_W'(400);
    repeat (6) bus_idle();
    reset = 1'b1;
    bus_idle();
    bus_idle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      accel_x_raw = ACCEL_W'(20 * (i + 1));
      accel_y_raw = ACCEL_W'(8 * (i + 1));
      if (i == 0) bus_read(12'hFF5, 32'h0, "frame_cnt_cleared");
      else bus_idle();
      bus_idle();
    end
    bus_read(12'hFF2, 32'd50, "accel_x_post_reset");
    bus_read(12'hFF3, 32'd20, "accel_y_post_reset");
    bus_read(12'hFF5, 32'h1, "frame_cnt_restart");
    bus_read(12'hFF4, 32'h1, "status_post_reset");

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
